booth_row_drain: RTL and testbench
==================================

Name: booth_row_drain

Overview:
- Downstream consumer for one systolic row of Booth PEs.
- Pulls finished signed partial-product words out of the rightmost PE using the PE read handshake (req toward PE, ready from PE).
- Buffers the words in a small FIFO and re-emits them as a valid/ready stream with a per-row index and last flag.
- Tracks the signed row sum and flags a stalled row with a timeout error.

Parameters:
- MATRIX_SIZE, 3, words drained per row (one per PE column).
- INPUT_WIDTH, 8, PE operand width.
- OUTPUT_WIDTH, 9, signed PE result width; matches PE default $clog2(MATRIX_SIZE*(2**INPUT_WIDTH))-1.
- FIFO_DEPTH, 4, output buffer entries; power of two, >=2.
- TIMEOUT, 64, max consecutive cycles with req high and no ready before error.

Ports:
- clk  input  1  clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begin draining a row (ignored unless IDLE).
- PE_left_read_req  output  1  read request to rightmost PE.
- PE_left_read_ready  input  1  PE has a valid word on left_final_partialmul_out.
- left_final_partialmul_out  input  OUTPUT_WIDTH  signed result word from PE.
- out_data  output  OUTPUT_WIDTH  signed FIFO head word.
- out_index  output  $clog2(MATRIX_SIZE)  column index of out_data.
- out_last  output  1  out_data is the row's final word.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from consumer.
- row_sum  output  OUTPUT_WIDTH+$clog2(MATRIX_SIZE)  signed sum of accepted words for current/last row.
- row_done  output  1  one-cycle pulse when row fully emitted.
- busy  output  1  state != IDLE.
- timeout_err  output  1  sticky until next start or reset.

Behaviour:
- Reset (async, reset_n=0): state IDLE; PE_left_read_req=0, out_valid=0, out_data=0, out_index=0, out_last=0, row_sum=0, row_done=0, busy=0, timeout_err=0, FIFO empty, all counters 0. Reset mid-row discards the FIFO and partial sum; no partial output.
- FSM states: IDLE, DRAIN, FLUSH, DONE.
  - IDLE -> DRAIN on start: clears rx_cnt, tx_cnt, row_sum, timeout_err, stall counter.
  - DRAIN -> FLUSH once rx_cnt reaches MATRIX_SIZE.
  - FLUSH -> DONE when FIFO empty and tx_cnt==MATRIX_SIZE.
  - DONE -> IDLE after one cycle; row_done=1 only in DONE.
- PE_left_read_req is registered; high in DRAIN when rx_cnt<MATRIX_SIZE and FIFO not full (counting a same-cycle pop as freeing space).
- Transfer occurs on a cycle with PE_left_read_req && PE_left_read_ready. On transfer:
  - left_final_partialmul_out is sampled and pushed into the FIFO with tag index=rx_cnt, last=(rx_cnt==MATRIX_SIZE-1).
  - rx_cnt increments.
  - row_sum += sign-extended word, visible next cycle.
- Ready without req is ignored; no transfer.
- Latency: PE word accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when FIFO was empty; otherwise in FIFO order.
- Output stream:
  - out_valid = FIFO not empty; out_data/out_index/out_last come from the FIFO head.
  - Pop on out_valid && out_ready; tx_cnt increments.
  - out_data holds stable while out_valid && !out_ready.
- FIFO: circular buffer with wrap-around read/write pointers plus an occupancy counter. Simultaneous push and pop when full or empty is legal and keeps occupancy unchanged (empty case: push must be registered first, so pop is not possible at empty). No overflow: req is never asserted when full.
- Timeout: the stall counter increments each cycle req=1 and ready=0, and clears on transfer.
  - On reaching TIMEOUT: timeout_err=1, req drops, FSM goes to FLUSH.
  - FLUSH then emits the already-buffered words; out_last is never set for the short row.
  - FLUSH -> DONE when FIFO empty (tx_cnt check waived on error).
- start while busy is ignored; no state change.
- row_sum holds its value through IDLE until the next start.

Test Plan:
- Nominal: MATRIX_SIZE=3, ready tied 1, out_ready=1, PE words 5, -7, 100 -> out (5,idx0),(-7,idx1),(100,idx2,last); row_sum=98; row_done one pulse; each word 1 cycle after its transfer.
- Back-pressure: out_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 transfers then req=0; out_data stable at first word; releasing out_ready drains all 3 words in order.
- Sparse ready: ready high only every 3rd cycle, words -256, 255, -1 -> 3 transfers, row_sum=-2, no error.
- Timeout: TIMEOUT=8, ready held 0 after first word 42 -> timeout_err=1 on the 8th stall cycle; req drops; 42 emitted with out_last=0; row_done pulses; next start clears timeout_err.
- Async reset mid-row: assert reset_n=0 after 1 transfer with out_valid=1 -> all outputs 0 immediately without a clock edge; after release, start plus 3 words gives a clean row with correct sum.
- start during DRAIN and ready without req in IDLE -> no effect; counts and sum unchanged.

Source files
------------

// File: rtl/booth_row_drain.sv
// booth_row_drain
//
// Drains one systolic row of Booth PEs. Finished signed partial-product words
// are pulled from the rightmost PE with a registered read request, buffered in
// a small circular FIFO tagged with their column index and a last flag, and
// re-emitted as a valid/ready stream. A signed running sum of the accepted
// words is kept per row, and a row whose PE stops answering is cut short with
// a sticky timeout error after which the already-buffered words are flushed.
//
// Ports
//   clk                        clock, rising edge
//   reset_n                    asynchronous active-low reset
//   start                      one-cycle pulse, begins a row (only from IDLE)
//   PE_left_read_req           registered read request toward the PE
//   PE_left_read_ready         PE holds a valid word
//   left_final_partialmul_out  signed word from the PE
//   out_data/out_index/out_last  FIFO head word, its column, final-word flag
//   out_valid / out_ready      output stream handshake
//   row_sum                    signed sum of words accepted this (or last) row
//   row_done                   one-cycle pulse once the row is fully emitted
//   busy                       controller not idle
//   timeout_err                sticky until the next start or reset
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; row_sum holds the previous row's result
// DRAIN  | requesting words from the PE until the row is in or it stalls
// FLUSH  | no more requests; emitting what is still buffered
// DONE   | single cycle, row_done asserted, then back to IDLE

module booth_row_drain #(
   parameter int MATRIX_SIZE  = 3,
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 9,
   parameter int FIFO_DEPTH   = 4,
   parameter int TIMEOUT      = 64,
   localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
   localparam int SUM_W = OUTPUT_WIDTH + $clog2(MATRIX_SIZE)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   output logic                           PE_left_read_req,
   input  logic                           PE_left_read_ready,
   input  logic signed [OUTPUT_WIDTH-1:0] left_final_partialmul_out,
   output logic signed [OUTPUT_WIDTH-1:0] out_data,
   output logic        [IDX_W-1:0]        out_index,
   output logic                           out_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [SUM_W-1:0]        row_sum,
   output logic                           row_done,
   output logic                           busy,
   output logic                           timeout_err
);

   localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int STL_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] ROW_LEN   = CNT_W'(MATRIX_SIZE);
   localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(MATRIX_SIZE - 1);
   localparam logic [OCC_W-1:0] FIFO_FULL = OCC_W'(FIFO_DEPTH);
   localparam logic [STL_W-1:0] STALL_MAX = STL_W'(TIMEOUT);

   // Widest result the PE row can produce for the chosen operand width.
   localparam int PE_OUT_W = $clog2(MATRIX_SIZE * (2 ** INPUT_WIDTH)) - 1;

   generate
      if ((OUTPUT_WIDTH < PE_OUT_W) || (FIFO_DEPTH < 2) ||
          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_chk
         $error("booth_row_drain: OUTPUT_WIDTH too narrow or FIFO_DEPTH not a power of two >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]          tx_cnt_q, tx_cnt_d;
   logic [STL_W-1:0]          stall_q, stall_d;
   logic                      req_q, req_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic signed [SUM_W-1:0]   sum_q, sum_d;

   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]          occ_q, occ_d;
   logic signed [OUTPUT_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
   logic signed [OUTPUT_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
   logic [IDX_W-1:0]          mem_idx_q [FIFO_DEPTH];
   logic [IDX_W-1:0]          mem_idx_d [FIFO_DEPTH];
   logic                      mem_last_q [FIFO_DEPTH];
   logic                      mem_last_d [FIFO_DEPTH];

   logic                      xfer;
   logic                      pop;
   logic                      timed_out;
   logic signed [SUM_W-1:0]   word_ext;

   always_comb begin
      xfer      = req_q && PE_left_read_ready;
      pop       = (occ_q != '0) && out_ready;
      word_ext  = SUM_W'(left_final_partialmul_out);

      state_d    = state_q;
      rx_cnt_d   = rx_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      stall_d    = stall_q;
      err_d      = err_q;
      sum_d      = sum_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      mem_data_d = mem_data_q;
      mem_idx_d  = mem_idx_q;
      mem_last_d = mem_last_q;

      // Pointers wrap naturally because the depth is a power of two.
      if (xfer) begin
         mem_data_d[wr_ptr_q] = left_final_partialmul_out;
         mem_idx_d[wr_ptr_q]  = IDX_W'(rx_cnt_q);
         mem_last_d[wr_ptr_q] = (rx_cnt_q == ROW_LAST);
         wr_ptr_d             = wr_ptr_q + 1'b1;
         rx_cnt_d             = rx_cnt_q + 1'b1;
         sum_d                = sum_q + word_ext;
         stall_d              = '0;
      end else if (req_q) begin
         stall_d = stall_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         tx_cnt_d = tx_cnt_q + 1'b1;
      end

      if (xfer && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!xfer && pop) begin
         occ_d = occ_q - 1'b1;
      end

      timed_out = req_q && !xfer && (stall_d == STALL_MAX);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_DRAIN;
               rx_cnt_d = '0;
               tx_cnt_d = '0;
               stall_d  = '0;
               err_d    = 1'b0;
               sum_d    = '0;
            end
         end
         S_DRAIN: begin
            if (timed_out) begin
               err_d   = 1'b1;
               state_d = S_FLUSH;
            end else if (rx_cnt_q == ROW_LEN) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // A timed-out row never reaches the full count, so only the
            // empty FIFO gates completion in that case.
            if ((occ_q == '0) && ((tx_cnt_q == ROW_LEN) || err_q)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The request is registered, so it is computed from next-cycle
      // occupancy; a pop this cycle therefore already frees a slot.
      req_d  = (state_d == S_DRAIN) && (rx_cnt_d < ROW_LEN) && (occ_d < FIFO_FULL);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         stall_q    <= '0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         sum_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         mem_data_q <= '{default: '0};
         mem_idx_q  <= '{default: '0};
         mem_last_q <= '{default: 1'b0};
      end else begin
         state_q    <= state_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         stall_q    <= stall_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         sum_q      <= sum_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         mem_data_q <= mem_data_d;
         mem_idx_q  <= mem_idx_d;
         mem_last_q <= mem_last_d;
      end
   end

   // Head fields are forced to zero while empty so the stream is quiet.
   assign out_valid        = (occ_q != '0);
   assign out_data         = out_valid ? mem_data_q[rd_ptr_q] : '0;
   assign out_index        = out_valid ? mem_idx_q[rd_ptr_q]  : '0;
   assign out_last         = out_valid && mem_last_q[rd_ptr_q];
   assign PE_left_read_req = req_q;
   assign row_sum          = sum_q;
   assign row_done         = done_q;
   assign busy             = busy_q;
   assign timeout_err      = err_q;

endmodule

// File: tb/tb_booth_row_drain.sv
module tb_booth_row_drain;

   localparam int MS    = 3;
   localparam int OW    = 9;
   localparam int DEPTH = 2;
   localparam int TO    = 8;
   localparam int IW    = $clog2(MS);
   localparam int SW    = OW + $clog2(MS);

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic                 pe_ready = 1'b0;
   logic                 out_ready = 1'b0;
   logic signed [OW-1:0] pe_word = '0;
   logic                 PE_left_read_req;
   logic signed [OW-1:0] out_data;
   logic [IW-1:0]        out_index;
   logic                 out_last;
   logic                 out_valid;
   logic signed [SW-1:0] row_sum;
   logic                 row_done;
   logic                 busy;
   logic                 timeout_err;

   booth_row_drain #(
      .MATRIX_SIZE (MS),
      .INPUT_WIDTH (8),
      .OUTPUT_WIDTH(OW),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT     (TO)
   ) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .start                    (start),
      .PE_left_read_req         (PE_left_read_req),
      .PE_left_read_ready       (pe_ready),
      .left_final_partialmul_out(pe_word),
      .out_data                 (out_data),
      .out_index                (out_index),
      .out_last                 (out_last),
      .out_valid                (out_valid),
      .out_ready                (out_ready),
      .row_sum                  (row_sum),
      .row_done                 (row_done),
      .busy                     (busy),
      .timeout_err              (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int idx;
      bit last;
   } ent_t;

   ent_t exp_q[$];
   int   pe_q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   rx_m = 0, sum_m = 0, stall_m = 0, n_xfer = 0, n_done = 0;
   int   cyc = 0, row_cyc = 0, rmode = 0, omode = 0;
   bit   to_m = 1'b0;
   bit   in_row = 1'b0;

   task automatic check_val(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict the coming edge from the
   // handshake rules, then look at the outputs just after the edge.
   task automatic tick();
      case (rmode)
         0:       pe_ready = 1'b1;
         1:       pe_ready = (cyc % 3 == 0);
         2:       pe_ready = ($urandom_range(0, 3) != 0);
         3:       pe_ready = (n_xfer == 0);
         4:       pe_ready = ($urandom_range(0, 3) == 0);
         default: pe_ready = 1'b0;
      endcase
      case (omode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         2:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = (row_cyc >= 10);
      endcase
      pe_word = (pe_q.size() != 0) ? OW'(pe_q[0]) : OW'($urandom);

      check_val("req_legal", PE_left_read_req &&
                (!in_row || to_m || rx_m >= MS || exp_q.size() >= DEPTH), 0);
      check_val("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
         check_val("out_data", out_data, exp_q[0].data);
         check_val("out_index", out_index, exp_q[0].idx);
         check_val("out_last", out_last, exp_q[0].last);
      end
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (PE_left_read_req && pe_ready) begin
         exp_q.push_back('{int'(pe_word), rx_m, (rx_m == MS - 1)});
         sum_m += int'(pe_word);
         rx_m++;
         stall_m = 0;
         n_xfer++;
         if (pe_q.size() != 0) void'(pe_q.pop_front());
      end else if (PE_left_read_req) begin
         stall_m++;
         if (stall_m == TO) to_m = 1'b1;
      end

      @(posedge clk);
      #1;
      cyc++;
      row_cyc++;
      if (row_done) n_done++;
      check_val("timeout_err", timeout_err, to_m);
   endtask

   task automatic clear_model();
      exp_q.delete();
      pe_q.delete();
      rx_m = 0; sum_m = 0; stall_m = 0; n_xfer = 0; n_done = 0; row_cyc = 0;
      to_m = 1'b0;
   endtask

   task automatic run_row(input int w0, input int w1, input int w2, input int rm,
                          input int om, input bit poke, input bit bp);
      int k;
      clear_model();
      pe_q.push_back(w0);
      pe_q.push_back(w1);
      pe_q.push_back(w2);
      rmode = rm;
      omode = om;
      in_row = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("busy_start", busy, 1);
      k = 0;
      while (n_done == 0 && k < 300) begin
         if (poke && k == 2) begin
            check_val("busy_poke", busy, 1);
            start = 1'b1;
            tick();
            start = 1'b0;
         end else begin
            tick();
         end
         k++;
         if (bp && row_cyc == 10) check_val("bp_xfers", n_xfer, DEPTH);
      end
      check_val("row_done_seen", n_done, 1);
      check_val("drained", exp_q.size(), 0);
      check_val("row_complete", (rx_m == MS) || to_m, 1);
      check_val("row_sum", row_sum, sum_m);
      in_row = 1'b0;
      tick();
      tick();
      check_val("row_done_once", n_done, 1);
      check_val("busy_idle", busy, 0);
      check_val("sum_hold", row_sum, sum_m);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_req"}, PE_left_read_req, 0);
      check_val({tag, "_valid"}, out_valid, 0);
      check_val({tag, "_data"}, out_data, 0);
      check_val({tag, "_index"}, out_index, 0);
      check_val({tag, "_last"}, out_last, 0);
      check_val({tag, "_sum"}, row_sum, 0);
      check_val({tag, "_done"}, row_done, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_err"}, timeout_err, 0);
   endtask

   initial begin
      int k;
      int saved_x;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();
      tick();

      // nominal row
      run_row(5, -7, 100, 0, 0, 1'b0, 1'b0);
      check_val("nom_sum", row_sum, 98);

      // back-pressure: consumer stalled for 10 cycles
      run_row(11, -22, 33, 0, 3, 1'b0, 1'b1);

      // sparse ready
      run_row(-256, 255, -1, 1, 0, 1'b0, 1'b0);
      check_val("sparse_sum", row_sum, -2);
      check_val("sparse_err", timeout_err, 0);

      // PE stalls after the first word
      run_row(42, 1, 2, 3, 0, 1'b0, 1'b0);
      check_val("to_err", timeout_err, 1);
      check_val("to_sum", row_sum, 42);
      check_val("to_xfers", n_xfer, 1);

      // next row clears the error; start pulse while busy is ignored
      run_row(-100, 50, 7, 0, 0, 1'b1, 1'b0);
      check_val("poke_sum", row_sum, -43);
      check_val("poke_xfers", n_xfer, MS);

      // ready with no request while idle
      saved_x = n_xfer;
      rmode = 0;
      omode = 0;
      repeat (5) tick();
      check_val("idle_xfers", n_xfer, saved_x);
      check_val("idle_sum", row_sum, -43);

      // asynchronous reset in the middle of a row
      clear_model();
      pe_q.push_back(17);
      pe_q.push_back(18);
      pe_q.push_back(19);
      rmode = 0;
      omode = 1;
      in_row = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (n_xfer < 1 && k < 20) begin
         tick();
         k++;
      end
      check_val("rst_pre_xfer", n_xfer, 1);
      check_val("rst_pre_valid", out_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      clear_model();
      in_row = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      omode = 0;
      tick();
      run_row(3, -4, 5, 0, 0, 1'b0, 1'b0);
      check_val("post_rst_sum", row_sum, 4);

      // randomized rows, some slow enough to time out
      for (int r = 0; r < 12; r++) begin
         run_row(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                 int'($urandom_range(0, 511)) - 256, (r % 3 == 2) ? 4 : 2, 2, 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
